// File: rtl/quad_count_sequencer.sv
// Sequential quadruple counter: loads up to MAX_N elements over a valid/ready
// stream, then counts index quadruples i<j<l<m whose element sum equals k.
// The work is one pair per cycle over a pair-sum histogram.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, n_elems, k    job request (accepted in IDLE), element count, target sum
//   in_valid/in_ready    element stream handshake, in_data element value
//   busy                 high in every state except IDLE
//   result_valid/ready   result handshake, result is the saturated count
module quad_count_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_N   = 16,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(MAX_N+1)-1:0]   n_elems,
    input  logic [DATA_W+1:0]            k,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         result_valid,
    output logic [COUNT_W-1:0]           result,
    input  logic                         result_ready
);

    localparam int unsigned NW = $clog2(MAX_N + 1);
    localparam int unsigned IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int unsigned SW = DATA_W + 1;
    localparam int unsigned HD = 1 << SW;
    localparam int unsigned TW = DATA_W + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_SCAN, S_ACCUM, S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NW-1:0]        r_n, w_n_nxt;
    logic [DATA_W+1:0]    r_k, w_k_nxt;
    logic [NW-1:0]        r_cnt, w_cnt_nxt;
    logic [NW-1:0]        r_j, w_j_nxt;
    logic [NW-1:0]        r_l, w_l_nxt;
    logic [NW-1:0]        r_i, w_i_nxt;
    logic [SW-1:0]        r_clr, w_clr_nxt;
    logic [COUNT_W-1:0]   r_acc, w_acc_nxt;
    logic                 r_in_ready, r_busy, r_result_valid;
    logic [COUNT_W-1:0]   r_result;

    logic [DATA_W-1:0]    r_elem [MAX_N];
    logic [COUNT_W-1:0]   r_hist [HD];

    logic                 w_accept;
    logic                 w_elem_we;
    logic                 w_hist_we;
    logic [SW-1:0]        w_hist_waddr;
    logic [COUNT_W-1:0]   w_hist_wdata;
    logic [DATA_W-1:0]    w_ej, w_el, w_ei;
    logic [TW-1:0]        w_t;
    logic                 w_t_ok;
    logic [COUNT_W-1:0]   w_hist_rd;
    logic [COUNT_W:0]     w_acc_sum;
    logic [COUNT_W-1:0]   w_acc_sat;
    logic [SW-1:0]        w_pair;
    logic [COUNT_W-1:0]   w_hist_cur;
    logic [COUNT_W-1:0]   w_hist_inc;

    assign w_accept = r_in_ready && in_valid;

    // Datapath reads: SCAN target lookup and ACCUM pair-sum increment
    assign w_ej      = r_elem[r_j[IW-1:0]];
    assign w_el      = r_elem[r_l[IW-1:0]];
    assign w_ei      = r_elem[r_i[IW-1:0]];
    assign w_t       = TW'(r_k) - TW'(w_ej) - TW'(w_el);
    assign w_t_ok    = !w_t[TW-1] && (w_t <= TW'(HD - 2));
    assign w_hist_rd = r_hist[w_t[SW-1:0]];
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_hist_rd};
    assign w_acc_sat = w_acc_sum[COUNT_W] ? '1 : w_acc_sum[COUNT_W-1:0];
    assign w_pair     = SW'(w_ei) + SW'(w_ej);
    assign w_hist_cur = r_hist[w_pair];
    assign w_hist_inc = (&w_hist_cur) ? w_hist_cur : w_hist_cur + COUNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath control; empty SCAN/ACCUM phases are skipped
    // so every j costs exactly n-1 cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_n_nxt      = r_n;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_j_nxt      = r_j;
        w_l_nxt      = r_l;
        w_i_nxt      = r_i;
        w_clr_nxt    = r_clr;
        w_acc_nxt    = r_acc;
        w_elem_we    = 1'b0;
        w_hist_we    = 1'b0;
        w_hist_waddr = '0;
        w_hist_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    w_n_nxt     = (n_elems > NW'(MAX_N)) ? NW'(MAX_N) : n_elems;
                    w_k_nxt     = k;
                    w_clr_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_j_nxt     = '0;
                    w_l_nxt     = '0;
                    w_i_nxt     = '0;
                    w_acc_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_hist_we    = 1'b1;
                w_hist_waddr = r_clr;
                w_clr_nxt    = r_clr + SW'(1);
                if (r_clr == SW'(HD - 1)) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (r_cnt == r_n) begin
                    // only an empty job gets here
                    w_state_nxt = S_DONE;
                end else if (w_accept) begin
                    w_elem_we = 1'b1;
                    w_cnt_nxt = r_cnt + NW'(1);
                    if (w_cnt_nxt == r_n) begin
                        if (r_n < NW'(4)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_SCAN;
                            w_j_nxt     = '0;
                            w_l_nxt     = NW'(1);
                        end
                    end
                end
            end
            S_SCAN: begin
                if (w_t_ok) w_acc_nxt = w_acc_sat;
                if (r_l == r_n - NW'(1)) begin
                    if (r_j == '0) begin
                        // ACCUM for j=0 is empty; go straight to SCAN for j=1
                        w_j_nxt = NW'(1);
                        w_l_nxt = NW'(2);
                    end else begin
                        w_state_nxt = S_ACCUM;
                        w_i_nxt     = '0;
                    end
                end else begin
                    w_l_nxt = r_l + NW'(1);
                end
            end
            S_ACCUM: begin
                w_hist_we    = 1'b1;
                w_hist_waddr = w_pair;
                w_hist_wdata = w_hist_inc;
                if (r_i == r_j - NW'(1)) begin
                    w_j_nxt = r_j + NW'(1);
                    w_i_nxt = '0;
                    if (w_j_nxt == r_n) begin
                        w_state_nxt = S_DONE;
                    end else if (w_j_nxt == r_n - NW'(1)) begin
                        // last j has no SCAN pairs; stay in ACCUM
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_l_nxt     = r_j + NW'(2);
                    end
                end else begin
                    w_i_nxt = r_i + NW'(1);
                end
            end
            S_DONE: begin
                if (result_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n            <= '0;
            r_k            <= '0;
            r_cnt          <= '0;
            r_j            <= '0;
            r_l            <= '0;
            r_i            <= '0;
            r_clr          <= '0;
            r_acc          <= '0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
        end else begin
            r_n            <= w_n_nxt;
            r_k            <= w_k_nxt;
            r_cnt          <= w_cnt_nxt;
            r_j            <= w_j_nxt;
            r_l            <= w_l_nxt;
            r_i            <= w_i_nxt;
            r_clr          <= w_clr_nxt;
            r_acc          <= w_acc_nxt;
            r_in_ready     <= (w_state_nxt == S_LOAD) && (w_cnt_nxt < w_n_nxt);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_result_valid <= (w_state_nxt == S_DONE);
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_result <= w_acc_nxt;
        end
    end

    // Element and histogram storage; CLEAR always runs before the histogram is read
    always_ff @(posedge clk) begin
        if (w_elem_we) r_elem[r_cnt[IW-1:0]] <= in_data;
        if (w_hist_we) r_hist[w_hist_waddr]  <= w_hist_wdata;
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result       = r_result;

endmodule

// File: doc/quad_count_sequencer.md
Name: quad_count_sequencer

Overview:
- Sequential counterpart of the team's combinational quadruple counter. Loads up to MAX_N unsigned elements over a valid/ready stream, then counts index quadruples i<j<l<m with a[i]+a[j]+a[l]+a[m] == k.
- Uses a one-pair-per-cycle schedule over a shared pair-sum histogram register array. Counts are exact, so no duplicate correction is needed.
- Sits between a host/stream source and a result consumer, and replaces the fully unrolled array where area matters.

Parameters:
- DATA_W, 8, element width in bits, unsigned.
- MAX_N, 16, maximum element count per job.
- COUNT_W, 16, result width; the result saturates.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request, accepted only in IDLE
- n_elems  in  $clog2(MAX_N+1)  element count for the job, sampled with start
- k  in  DATA_W+2  target sum, unsigned, sampled with start
- in_valid  in  1  element stream valid
- in_data  in  DATA_W  element value
- in_ready  out  1  high only in LOAD
- busy  out  1  high in every state except IDLE
- result_valid  out  1  result available
- result  out  COUNT_W  quadruple count
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, busy=0, result_valid=0, result=0; all indices and the accumulator cleared. Histogram contents do not need to be reset, because CLEAR always precedes use.
- Storage:
  - elem[MAX_N] of DATA_W bits.
  - hist[2^(DATA_W+1)] of COUNT_W bits, indexed by pair sum (DATA_W+1 bits).
  - acc of COUNT_W bits.
- IDLE:
  - On start, latch n = min(n_elems, MAX_N) and latch k.
  - Go to CLEAR. start is ignored while busy.
- CLEAR:
  - Writes hist[a]=0 for a = 0..2^(DATA_W+1)-1, one entry per cycle.
  - Takes exactly 2^(DATA_W+1) cycles, then goes to LOAD.
- LOAD:
  - in_ready=1. Each cycle with in_valid&&in_ready stores elem[cnt]=in_data and increments cnt.
  - After n accepted beats, in_ready drops in the next cycle.
  - If n<4: set acc=0 and go to DONE. Otherwise set j=0 and go to SCAN.
  - If n==0: LOAD lasts exactly one cycle with no accepts.
- SCAN (fixed j, l = j+1..n-1, one l per cycle):
  - Compute t = k - elem[j] - elem[l] in signed DATA_W+3 arithmetic.
  - If 0 <= t <= 2^(DATA_W+1)-2: acc += hist[t]. Otherwise add 0.
  - When j == n-1 the phase is empty and takes 0 cycles. Then go to ACCUM.
- ACCUM (i = 0..j-1, one i per cycle):
  - hist[elem[i]+elem[j]] += 1. The histogram increment saturates at all-ones.
  - When j == 0 the phase is empty. After the phase, j++.
  - If j == n, go to DONE; otherwise return to SCAN.
- Ordering invariant: hist holds only pairs with both indices < j when SCAN for j runs. This yields an exact i<i'<j<l count.
- Compute latency: exactly n*(n-1) cycles from the first SCAN cycle to entry into DONE.
- acc saturation: acc saturates at 2^COUNT_W-1 and never wraps.
- DONE:
  - result=acc and result_valid=1, from the first DONE cycle onward.
  - result and result_valid are held stable until result_ready is sampled high.
  - That handshake cycle returns to IDLE with result_valid=0.
  - A start asserted in the same cycle is ignored.
- Simultaneous read/write: SCAN and ACCUM never overlap, so there is no hist read-during-write hazard.
- Reset mid-job: the job is aborted. No result is produced and in_ready drops immediately.

Test Plan:
- Basic count: n=5, k=10, stream 1,2,3,4,5 -> in_ready high for exactly 5 accepted beats; result=1; compute phase = 20 cycles; result_valid held until result_ready.
- All-equal combinatorics: n=6, k=4, all elements 1 -> result=15 (C(6,4)). Repeat with k=5 -> result=0.
- Short job: n=3, k=6, stream 2,2,2 -> no SCAN/ACCUM cycles; result=0 right after the 3rd beat.
- Out-of-range target: n=4, k=1023 (max DATA_W+2), stream 255,255,255,255 -> result=1020-sum mismatch -> result=0. Negative-t path: k=0 with nonzero elements -> result=0.
- Saturation and clamping: COUNT_W=8, n_elems=20 (clamped to 16), all zeros, k=0 -> exactly 16 beats accepted; result=255 (true 1820).
- Reset and backpressure: assert rst_n low during SCAN -> all outputs return to 0 asynchronously, state IDLE; a new job with n=5, k=10 still yields 1. Also hold result_ready low for 10 cycles -> result stable, start ignored.
